// File: rtl/demux1to3_buf.sv
// demux1to3_buf: steers one WIDTH-bit stream into three buffered destination
// channels (counter, accumulator, output). Select 2'b11 discards the word and
// raises a sticky error flag.
// Optional build macro DEMUX_ERR_CNT_EN adds an 8-bit saturating discard
// counter on port err_cnt.
module demux1to3_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic             err_flag
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Storage is reset as well so the head outputs are never X after reset
    // and a reset leaves no stale words behind.
    logic [WIDTH-1:0] mem  [3][DEPTH];
    logic [AW-1:0]    wptr [3];
    logic [AW-1:0]    rptr [3];
    logic [AW:0]      cnt  [3];

    logic [2:0] full;
    logic [2:0] push;
    logic [2:0] pop;
    logic       discard;

    assign full[0]   = (cnt[0] == FULL_CNT);
    assign full[1]   = (cnt[1] == FULL_CNT);
    assign full[2]   = (cnt[2] == FULL_CNT);
    assign out_valid = {(cnt[2] != '0), (cnt[1] != '0), (cnt[0] != '0)};
    assign pop       = out_valid & out_ready;

    assign out0_data = mem[0][rptr[0]];
    assign out1_data = mem[1][rptr[1]];
    assign out2_data = mem[2][rptr[2]];

    // Input acceptance: ready depends only on the selected FIFO's fill level,
    // never on out_ready, so no combinational path runs from output to input.
    always_comb begin
        in_ready = 1'b1;
        push     = 3'b000;
        discard  = 1'b0;
        case (in_sel)
            2'b00:   in_ready = !full[0];
            2'b01:   in_ready = !full[1];
            2'b10:   in_ready = !full[2];
            default: in_ready = 1'b1;
        endcase
        if (in_valid) begin
            case (in_sel)
                2'b00:   push[0] = !full[0];
                2'b01:   push[1] = !full[1];
                2'b10:   push[2] = !full[2];
                default: discard = 1'b1;
            endcase
        end
    end

    // Per-channel FIFO pointers, counts and storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push[c]) begin
                    mem[c][wptr[c]] <= in_data;
                    wptr[c]         <= wptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rptr[c] <= rptr[c] + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt[c] <= cnt[c] + 1'b1;
                    2'b01:   cnt[c] <= cnt[c] - 1'b1;
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // Sticky discard indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (discard) begin
            err_flag <= 1'b1;
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    // Saturating count of discarded words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (discard && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_demux1to3_buf.sv
// Testbench for demux1to3_buf: directed vector table plus a queue-based
// reference model for wrap-around, random traffic, discard and reset cases.
module tb_demux1to3_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] out0_data;
    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic             err_flag;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    demux1to3_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_flag  (err_flag)
`ifdef DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [15:0] q [3][$];
    logic        err_m = 1'b0;
    int          cnt_m = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [1:0]  s;
        logic [2:0]  ordy;
        logic        exp_rdy;
        logic [2:0]  exp_vld;
        int          chk;     // channel whose head is checked after the edge, 3 = none
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] head(input int c);
        case (c)
            0:       return out0_data;
            1:       return out1_data;
            default: return out2_data;
        endcase
    endfunction

    // One clock of traffic checked against the queue model. Called at a
    // falling edge; returns at the next falling edge.
    task automatic sb_cycle(input logic v, input logic [15:0] d, input logic [1:0] s,
                            input logic [2:0] ordy, output logic acc);
        logic       exp_rdy;
        logic [2:0] ev;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        #1;
        exp_rdy = (s == 2'b11) ? 1'b1 : (q[int'(s)].size() < DEPTH);
        chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int c = 0; c < 3; c++) ev[c] = (q[c].size() != 0);
        chk("sb_out_valid", {29'd0, out_valid}, {29'd0, ev});
        for (int c = 0; c < 3; c++) begin
            if (ev[c]) chk($sformatf("sb_head_ch%0d", c), {16'd0, head(c)}, {16'd0, q[c][0]});
        end
        for (int c = 0; c < 3; c++) begin
            if (ev[c] && ordy[c]) void'(q[c].pop_front());
        end
        acc = v && exp_rdy;
        if (acc) begin
            if (s == 2'b11) begin
                err_m = 1'b1;
                if (cnt_m < 255) cnt_m++;
            end else begin
                q[int'(s)].push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("sb_err_flag", {31'd0, err_flag}, {31'd0, err_m});
`ifdef DEMUX_ERR_CNT_EN
        chk("sb_err_cnt", {24'd0, err_cnt}, cnt_m);
`endif
    endtask

    initial begin
        logic        acc;
        logic        pv;
        logic [15:0] pd;
        logic [1:0]  ps;

        //          v     d        s      ordy    rdy   vld     chk d
        vecs[0]  = '{1'b1, 16'h0078, 2'b01, 3'b000, 1'b1, 3'b010, 1, 16'h0078};
        vecs[1]  = '{1'b0, 16'h0000, 2'b01, 3'b010, 1'b1, 3'b000, 3, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0001, 2'b00, 3'b000, 1'b1, 3'b001, 0, 16'h0001};
        vecs[3]  = '{1'b1, 16'h0002, 2'b00, 3'b000, 1'b1, 3'b001, 0, 16'h0001};
        vecs[4]  = '{1'b0, 16'h0000, 2'b00, 3'b000, 1'b0, 3'b001, 0, 16'h0001};
        vecs[5]  = '{1'b0, 16'h0000, 2'b10, 3'b000, 1'b1, 3'b001, 0, 16'h0001};
        vecs[6]  = '{1'b1, 16'h0003, 2'b00, 3'b000, 1'b0, 3'b001, 0, 16'h0001};
        vecs[7]  = '{1'b0, 16'h0000, 2'b00, 3'b001, 1'b0, 3'b001, 0, 16'h0002};
        vecs[8]  = '{1'b0, 16'h0000, 2'b00, 3'b001, 1'b1, 3'b000, 3, 16'h0000};
        vecs[9]  = '{1'b1, 16'h0005, 2'b10, 3'b000, 1'b1, 3'b100, 2, 16'h0005};
        vecs[10] = '{1'b1, 16'h0018, 2'b10, 3'b100, 1'b1, 3'b100, 2, 16'h0018};
        vecs[11] = '{1'b0, 16'h0000, 2'b10, 3'b100, 1'b1, 3'b000, 3, 16'h0000};
        vecs[12] = '{1'b1, 16'h00A1, 2'b01, 3'b000, 1'b1, 3'b010, 1, 16'h00A1};
        vecs[13] = '{1'b1, 16'h00A2, 2'b01, 3'b000, 1'b1, 3'b010, 1, 16'h00A1};
        vecs[14] = '{1'b1, 16'h00A3, 2'b01, 3'b010, 1'b0, 3'b010, 1, 16'h00A2};
        vecs[15] = '{1'b0, 16'h0000, 2'b01, 3'b010, 1'b1, 3'b000, 3, 16'h0000};
        vecs[16] = '{1'b1, 16'h0011, 2'b00, 3'b000, 1'b1, 3'b001, 0, 16'h0011};
        vecs[17] = '{1'b1, 16'h0022, 2'b10, 3'b001, 1'b1, 3'b100, 2, 16'h0022};
        vecs[18] = '{1'b0, 16'h0000, 2'b10, 3'b100, 1'b1, 3'b000, 3, 16'h0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'b00;
        out_ready = 3'b000;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
        chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("rst_out0", {16'd0, out0_data}, 32'd0);
        chk("rst_out1", {16'd0, out1_data}, 32'd0);
        chk("rst_out2", {16'd0, out2_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            in_sel    = vecs[i].s;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), {29'd0, out_valid}, {29'd0, vecs[i].exp_vld});
            if (vecs[i].chk != 3)
                chk($sformatf("vec%0d_data", i), {16'd0, head(vecs[i].chk)}, {16'd0, vecs[i].exp_d});
        end
        chk("vec_err_flag", {31'd0, err_flag}, 32'd0);

        // wrap-around through ch0: pop while pushing, then drain
        for (int k = 1; k <= 5; k++) sb_cycle(1'b1, 16'(k), 2'b00, 3'b001, acc);
        for (int k = 0; k < 3; k++) sb_cycle(1'b0, 16'h0000, 2'b00, 3'b001, acc);

        // random mixed traffic; a stalled word is held stable until accepted
        pv = 1'b0; pd = '0; ps = 2'b00;
        for (int n = 0; n < 400; n++) begin
            logic        v;
            logic [15:0] d;
            logic [1:0]  s;
            if (pv) begin
                v = 1'b1; d = pd; s = ps;
            end else begin
                v = 1'($urandom_range(0, 1));
                d = 16'($urandom);
                s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            sb_cycle(v, d, s, 3'($urandom_range(0, 7)), acc);
            pv = v && !acc; pd = d; ps = s;
        end
        for (int k = 0; k < 4; k++) sb_cycle(1'b0, 16'h0000, 2'b00, 3'b111, acc);

        // discard flood
        for (int k = 0; k < 300; k++) sb_cycle(1'b1, 16'hBEEF, 2'b11, 3'b000, acc);
        chk("discard_err_flag", {31'd0, err_flag}, 32'd1);
`ifdef DEMUX_ERR_CNT_EN
        chk("discard_err_cnt_sat", {24'd0, err_cnt}, 32'hFF);
`endif

        // reset mid-stream with two words held in ch1
        sb_cycle(1'b1, 16'h0C01, 2'b01, 3'b000, acc);
        sb_cycle(1'b1, 16'h0C02, 2'b01, 3'b000, acc);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", {29'd0, out_valid}, 32'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {29'd0, out_valid}, 32'd0);
        chk("midrst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("midrst_out1", {16'd0, out1_data}, 32'd0);
`ifdef DEMUX_ERR_CNT_EN
        chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        for (int c = 0; c < 3; c++) q[c].delete();
        err_m = 1'b0;
        cnt_m = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("postrst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);
        sb_cycle(1'b1, 16'h0ABC, 2'b01, 3'b000, acc);
        sb_cycle(1'b0, 16'h0000, 2'b01, 3'b010, acc);
        sb_cycle(1'b0, 16'h0000, 2'b01, 3'b000, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
